// File: rtl/alu_muldiv_exec_if.sv
// Execute-stage bus between the issue logic and alu_muldiv_exec: the request
// side (start, decoded code, operands, shift amount) and the response side
// (registered result/flag, valid pulse, stall request and the HI/LO registers).
interface alu_muldiv_exec_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [5:0]       alu_ctrl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       shamt;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             valid;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, alu_ctrl, a, b, shamt,
    input  result, zero, valid, busy, hi, lo
  );

  modport slave (
    input  start, alu_ctrl, a, b, shamt,
    output result, zero, valid, busy, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_exec.sv
// Execute-stage datapath: single-cycle ALU ops, branch flags, and an iterative
// 32-step shift-add multiplier / restoring divider writing HI/LO.
// Optional build macro MULDIV_FAST_EN: MULT finishes in one cycle through a
// combinational signed multiply; DIV stays iterative.
module alu_muldiv_exec #(
  parameter int WIDTH    = 32,
  parameter int MD_STEPS = WIDTH
) (
  input logic              clk,
  input logic              rst_n,
  alu_muldiv_exec_if.slave bus
);
  localparam int CW = $clog2(MD_STEPS);
  localparam logic [CW-1:0] LastStep = CW'(MD_STEPS - 1);

  localparam logic [4:0] OpAnd  = 5'b00000, OpOr   = 5'b00010, OpXor  = 5'b00110;
  localparam logic [4:0] OpNor  = 5'b11000, OpAdd  = 5'b00100, OpSub  = 5'b01100;
  localparam logic [4:0] OpSlt  = 5'b01110, OpSlti = 5'b00111, OpLui  = 5'b00011;
  localparam logic [4:0] OpSll  = 5'b10000, OpSrl  = 5'b10010, OpSra  = 5'b10100;
  localparam logic [4:0] OpSllv = 5'b10110, OpMfhi = 5'b01111, OpMflo = 5'b00001;
  localparam logic [4:0] OpBne  = 5'b11010, OpBlez = 5'b11100, OpBgtz = 5'b11110;
  localparam logic [4:0] OpMult = 5'b01000, OpDiv  = 5'b01010;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
  stateT state, nextState;

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opMag;
  logic               negQ, negR, divOp;
  logic [CW-1:0]      count;
  logic [WIDTH-1:0]   resultReg, hiReg, loReg;
  logic               zeroReg, validReg;

  logic               loadMul, loadDiv, issue, finish;
  logic [4:0]         code;
  logic               isMult, isDiv, startMulIter;
  logic [WIDTH-1:0]   absA, absB, aluResult;
  logic               aluZero;
  logic [WIDTH:0]     mulSum, divShift, divDiff;
  logic [2*WIDTH-1:0] mulFinal;
  logic [WIDTH-1:0]   quoFinal, remFinal, finalHi, finalLo;

  assign code   = bus.alu_ctrl[4:0];
  assign isMult = (code == OpMult);
  assign isDiv  = (code == OpDiv);
  assign absA   = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign absB   = bus.b[WIDTH-1] ? -bus.b : bus.b;

`ifdef MULDIV_FAST_EN
  logic [2*WIDTH-1:0] fastProd;
  assign fastProd     = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign startMulIter = 1'b0;
`else
  assign startMulIter = isMult;
`endif

  // Multiply step adds the multiplicand into the upper half; divide step
  // does a trial subtract of the divisor from the shifted partial remainder.
  assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opMag} : '0);
  assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign divDiff  = divShift - {1'b0, opMag};

  // Signs are applied to the unsigned magnitudes once the engine finishes;
  // a zero divisor forces an all-ones quotient while the remainder is the dividend.
  assign mulFinal = negQ ? -acc : acc;
  assign quoFinal = (opMag == '0) ? '1 : (negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign remFinal = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign finalHi  = divOp ? remFinal : mulFinal[2*WIDTH-1:WIDTH];
  assign finalLo  = divOp ? quoFinal : mulFinal[WIDTH-1:0];

  // Single-cycle result and branch/zero flag for the presented code.
  always_comb begin
    aluResult = '0;
    aluZero   = 1'b0;
    case (code)
      OpAnd:                      aluResult = bus.a & bus.b;
      OpOr:                       aluResult = bus.a | bus.b;
      OpXor:                      aluResult = bus.a ^ bus.b;
      OpNor:                      aluResult = ~(bus.a | bus.b);
      OpAdd:                      aluResult = bus.a + bus.b;
      OpSlt, OpSlti:              aluResult = WIDTH'($signed(bus.a) < $signed(bus.b));
      OpLui:                      aluResult = bus.b << 16;
      OpSll:                      aluResult = bus.b << bus.shamt;
      OpSrl:                      aluResult = bus.b >> bus.shamt;
      OpSra:                      aluResult = $signed(bus.b) >>> bus.shamt;
      OpSllv:                     aluResult = bus.b << bus.a[4:0];
      OpMfhi:                     aluResult = hiReg;
      OpMflo:                     aluResult = loReg;
      OpSub, OpBne, OpBlez, OpBgtz: aluResult = bus.a - bus.b;
      default:                    aluResult = '0;
    endcase
    case (code)
      OpBne:   aluZero = (bus.a != bus.b);
      OpBlez:  aluZero = bus.a[WIDTH-1] | (bus.a == '0);
      OpBgtz:  aluZero = ~bus.a[WIDTH-1] & (bus.a != '0);
      OpSub:   aluZero = (bus.a == bus.b);
      default: aluZero = (aluResult == '0);
    endcase
  end

  // State register; reset aborts any multiply/divide in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    nextState = state;
    loadMul   = 1'b0;
    loadDiv   = 1'b0;
    issue     = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (startMulIter) begin
            loadMul   = 1'b1;
            nextState = MUL;
          end else if (isDiv) begin
            loadDiv   = 1'b1;
            nextState = DIV;
          end else begin
            issue = 1'b1;
          end
        end
      end
      MUL, DIV: if (count == LastStep) nextState = DONE;
      DONE: begin
        finish    = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath registers: operand capture, engine iteration, result/HI/LO writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      opMag     <= '0;
      negQ      <= 1'b0;
      negR      <= 1'b0;
      divOp     <= 1'b0;
      count     <= '0;
      resultReg <= '0;
      zeroReg   <= 1'b0;
      validReg  <= 1'b0;
      hiReg     <= '0;
      loReg     <= '0;
    end else begin
      validReg <= 1'b0;
      if (issue) begin
        validReg <= 1'b1;
`ifdef MULDIV_FAST_EN
        if (isMult) begin
          hiReg     <= fastProd[2*WIDTH-1:WIDTH];
          loReg     <= fastProd[WIDTH-1:0];
          resultReg <= fastProd[WIDTH-1:0];
          zeroReg   <= (fastProd[WIDTH-1:0] == '0);
        end else begin
          resultReg <= aluResult;
          zeroReg   <= aluZero;
        end
`else
        resultReg <= aluResult;
        zeroReg   <= aluZero;
`endif
      end
      if (loadMul) begin
        acc   <= {{WIDTH{1'b0}}, absB};
        opMag <= absA;
        negQ  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        negR  <= 1'b0;
        divOp <= 1'b0;
        count <= '0;
      end
      if (loadDiv) begin
        acc   <= {{WIDTH{1'b0}}, absA};
        opMag <= absB;
        negQ  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        negR  <= bus.a[WIDTH-1];
        divOp <= 1'b1;
        count <= '0;
      end
      if (state == MUL) begin
        acc   <= {mulSum, acc[WIDTH-1:1]};
        count <= count + CW'(1);
      end
      if (state == DIV) begin
        acc   <= divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {divDiff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        count <= count + CW'(1);
      end
      if (finish) begin
        hiReg     <= finalHi;
        loReg     <= finalLo;
        resultReg <= finalLo;
        zeroReg   <= (finalLo == '0);
        validReg  <= 1'b1;
      end
    end
  end

  assign bus.result = resultReg;
  assign bus.zero   = zeroReg;
  assign bus.valid  = validReg;
  assign bus.busy   = (state != IDLE);
  assign bus.hi     = hiReg;
  assign bus.lo     = loReg;
endmodule

// File: tb/tb_alu_muldiv_exec.sv
// Self-checking bench for alu_muldiv_exec: directed corner cases plus random
// single-cycle and MULT/DIV traffic checked against an arithmetic reference.
// Honors MULDIV_FAST_EN for the expected MULT latency.
module tb_alu_muldiv_exec;
  localparam int WIDTH = 32;

  localparam logic [4:0] CodeAnd  = 5'b00000, CodeOr   = 5'b00010, CodeXor  = 5'b00110;
  localparam logic [4:0] CodeNor  = 5'b11000, CodeAdd  = 5'b00100, CodeSub  = 5'b01100;
  localparam logic [4:0] CodeSlt  = 5'b01110, CodeSlti = 5'b00111, CodeLui  = 5'b00011;
  localparam logic [4:0] CodeSll  = 5'b10000, CodeSrl  = 5'b10010, CodeSra  = 5'b10100;
  localparam logic [4:0] CodeSllv = 5'b10110, CodeMfhi = 5'b01111, CodeMflo = 5'b00001;
  localparam logic [4:0] CodeBne  = 5'b11010, CodeBlez = 5'b11100, CodeBgtz = 5'b11110;
  localparam logic [4:0] CodeMult = 5'b01000, CodeDiv  = 5'b01010;

  localparam logic [4:0] SingleCodes [21] = '{
    5'b00000, 5'b00010, 5'b00110, 5'b11000, 5'b00100, 5'b01100, 5'b01110,
    5'b00111, 5'b00011, 5'b10000, 5'b10010, 5'b10100, 5'b10110, 5'b01111,
    5'b00001, 5'b11010, 5'b11100, 5'b11110, 5'b00101, 5'b01001, 5'b11111
  };

  logic clk = 1'b0;
  logic rst_n;
  int checkCount = 0;
  int failCount  = 0;
  logic [31:0] refHi = '0;
  logic [31:0] refLo = '0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  alu_muldiv_exec_if #(.WIDTH(WIDTH)) bus ();
  alu_muldiv_exec #(.WIDTH(WIDTH), .MD_STEPS(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Present one request for a single clock; returns #1 after the sampling edge.
  task automatic applyStimulus(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] sh);
    @(negedge clk);
    bus.alu_ctrl = {1'($urandom_range(0, 1)), code};
    bus.a        = a;
    bus.b        = b;
    bus.shamt    = sh;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Reference for single-cycle codes, written from the instruction semantics.
  function automatic void refSingle(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] sh, output logic [31:0] r, output logic z);
    int sa, sb;
    sa = a;
    sb = b;
    case (code)
      CodeAnd:                r = a & b;
      CodeOr:                 r = a | b;
      CodeXor:                r = a ^ b;
      CodeNor:                r = ~(a | b);
      CodeAdd:                r = a + b;
      CodeSlt, CodeSlti:      r = (sa < sb) ? 32'd1 : 32'd0;
      CodeLui:                r = {b[15:0], 16'h0000};
      CodeSll:                r = b << sh;
      CodeSrl:                r = b >> sh;
      CodeSra:                r = sb >>> sh;
      CodeSllv:               r = b << a[4:0];
      CodeMfhi:               r = refHi;
      CodeMflo:               r = refLo;
      CodeSub, CodeBne, CodeBlez, CodeBgtz: r = a - b;
      default:                r = 32'd0;
    endcase
    z = (r == 32'd0);
    case (code)
      CodeSub:  z = (a == b);
      CodeBne:  z = (a != b);
      CodeBlez: z = (sa <= 0);
      CodeBgtz: z = (sa > 0);
      default:  ;
    endcase
  endfunction

  task automatic runSingle(input string tag, input logic [4:0] code, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] sh,
                           input logic [31:0] expR, input logic expZ);
    applyStimulus(code, a, b, sh);
    checkOutput({tag, "_valid"}, bus.valid, 1);
    checkOutput({tag, "_result"}, bus.result, expR);
    checkOutput({tag, "_zero"}, bus.zero, expZ);
  endtask

  task automatic runModel(input string tag, input logic [4:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    logic z;
    refSingle(code, a, b, sh, r, z);
    runSingle(tag, code, a, b, sh, r, z);
  endtask

  // Issue MULT/DIV, measure busy and latency, check HI/LO against signed arithmetic.
  task automatic runMulDiv(input string tag, input logic [4:0] code, input logic [31:0] a,
                           input logic [31:0] b, input bit injectAdd, input bit checkPulse);
    longint la, lb, p, q, rm;
    int ia, ib, cyc, busyCnt, expLat, expBusy;
    logic [31:0] expHi, expLo;
    ia = a;
    ib = b;
    la = ia;
    lb = ib;
    expLat  = 34;
    expBusy = 33;
    if (code == CodeMult) begin
      p     = la * lb;
      expHi = p[63:32];
      expLo = p[31:0];
`ifdef MULDIV_FAST_EN
      expLat  = 1;
      expBusy = 0;
`endif
    end else if (b == 32'd0) begin
      expLo = 32'hFFFF_FFFF;
      expHi = a;
    end else begin
      q     = la / lb;
      rm    = la % lb;
      expLo = q[31:0];
      expHi = rm[31:0];
    end
    applyStimulus(code, a, b, 5'($urandom));
    cyc     = 1;
    busyCnt = 0;
    while (bus.valid !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busyCnt++;
      if (injectAdd && cyc == 5) begin
        bus.alu_ctrl = {1'b0, CodeAdd};
        bus.a        = $urandom;
        bus.b        = $urandom;
        bus.start    = 1'b1;
      end
      if (injectAdd && cyc == 10) bus.start = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.start = 1'b0;
    checkOutput({tag, "_latency"}, cyc, expLat);
    checkOutput({tag, "_busyCycles"}, busyCnt, expBusy);
    checkOutput({tag, "_busyEnd"}, bus.busy, 0);
    checkOutput({tag, "_hi"}, bus.hi, expHi);
    checkOutput({tag, "_lo"}, bus.lo, expLo);
    checkOutput({tag, "_result"}, bus.result, expLo);
    checkOutput({tag, "_zero"}, bus.zero, expLo == 32'd0);
    refHi = expHi;
    refLo = expLo;
    if (checkPulse) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_pulse"}, bus.valid, 0);
    end
  endtask

  // Main sequence: reset, directed corners, reset abort, random traffic.
  initial begin
    logic [4:0] rc;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.alu_ctrl = '0;
    bus.a        = '0;
    bus.b        = '0;
    bus.shamt    = '0;
    #12;
    checkOutput("reset_result", bus.result, 0);
    checkOutput("reset_zero", bus.zero, 0);
    checkOutput("reset_valid", bus.valid, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_hi", bus.hi, 0);
    checkOutput("reset_lo", bus.lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    runSingle("and", CodeAnd, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 1'b0);
    runSingle("nor", CodeNor, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h000F000F, 1'b0);
    runSingle("sra", CodeSra, 32'h80000000, 32'h80000000, 5'd4, 32'hF8000000, 1'b0);
    runSingle("lui", CodeLui, 32'h0, 32'h00001234, 5'd0, 32'h12340000, 1'b0);
    runSingle("blez", CodeBlez, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1);
    runSingle("bgtz", CodeBgtz, 32'h80000000, 32'h0, 5'd0, 32'h80000000, 1'b0);
    runSingle("bne", CodeBne, 32'd3, 32'd3, 5'd0, 32'h0, 1'b0);
    runSingle("badcode", 5'b00101, 32'd9, 32'd4, 5'd0, 32'h0, 1'b1);

    runMulDiv("multNeg", CodeMult, 32'hFFFFFFFD, 32'h7FFFFFFF, 1'b0, 1'b1);
    checkOutput("multNeg_hiConst", bus.hi, 32'hFFFFFFFE);
    checkOutput("multNeg_loConst", bus.lo, 32'h80000003);
    runMulDiv("divNeg", CodeDiv, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
    checkOutput("divNeg_loConst", bus.lo, 32'hFFFFFFFD);
    checkOutput("divNeg_hiConst", bus.hi, 32'hFFFFFFFF);
    runMulDiv("divZero", CodeDiv, 32'd5, 32'd0, 1'b0, 1'b1);
    runMulDiv("divOvf", CodeDiv, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
    checkOutput("divOvf_loConst", bus.lo, 32'h80000000);
    runMulDiv("divBusyAdd", CodeDiv, 32'd1000, 32'd7, 1'b1, 1'b0);
    runSingle("mfloAfterDone", CodeMflo, $urandom, $urandom, 5'd0, 32'd142, 1'b0);
    runSingle("mfhiAfterDone", CodeMfhi, $urandom, $urandom, 5'd0, 32'd6, 1'b0);

    applyStimulus(CodeMult, 32'd7, 32'd9, 5'd0);
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_hi", bus.hi, 0);
    checkOutput("abort_lo", bus.lo, 0);
    checkOutput("abort_busy", bus.busy, 0);
    checkOutput("abort_valid", bus.valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    refHi = '0;
    refLo = '0;
    runSingle("subAfterAbort", CodeSub, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1);
    runModel("mfhiAfterAbort", CodeMfhi, 32'd0, 32'd0, 5'd0);

    for (int i = 0; i < 40; i++) begin
      rc = SingleCodes[$urandom_range(0, 20)];
      runModel("randSingle", rc, $urandom, ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom, 5'($urandom));
    end
    for (int i = 0; i < 8; i++) begin
      rc = ($urandom_range(0, 1) == 1) ? CodeMult : CodeDiv;
      runMulDiv("randMulDiv", rc, $urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom, 1'b0, 1'b1);
      runModel("randMfhi", CodeMfhi, $urandom, $urandom, 5'd0);
      runModel("randMflo", CodeMflo, $urandom, $urandom, 5'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
